// File: rtl/ivector_pkg.sv
// Shared definitions for the ivector response path: default sizes and the
// {meth, v} response record used by both the FIFO bank and the heard arbiter.
package ivector_pkg;

  localparam int IVECTOR_NREQ       = 10;
  localparam int IVECTOR_DATA_WIDTH = 32;
  localparam int IVECTOR_METH_WIDTH = 32;

  typedef struct packed {
    logic [IVECTOR_METH_WIDTH-1:0] meth;
    logic [IVECTOR_DATA_WIDTH-1:0] v;
  } ivector_heard_t;

endpackage

// File: rtl/ivector_heard_arbiter_if.sv
// Bundle between the per-method FIFO bank, the heard arbiter and the heard consumer.
// master = arbiter side, slave = FIFO bank / consumer side.
interface ivector_heard_arbiter_if
  import ivector_pkg::*;
#(
  parameter int NREQ       = IVECTOR_NREQ,
  parameter int DATA_WIDTH = IVECTOR_DATA_WIDTH,
  parameter int METH_WIDTH = IVECTOR_METH_WIDTH
);

  logic [NREQ-1:0]            req_first__RDY;
  logic [NREQ*DATA_WIDTH-1:0] req_first;
  logic [NREQ-1:0]            req_deq__ENA;
  logic                       out_heard__ENA;
  logic [METH_WIDTH-1:0]      out_heard_meth;
  logic [DATA_WIDTH-1:0]      out_heard_v;
  logic                       out_heard__RDY;

  modport master (
    input  req_first__RDY,
    input  req_first,
    output req_deq__ENA,
    output out_heard__ENA,
    output out_heard_meth,
    output out_heard_v,
    input  out_heard__RDY
  );

  modport slave (
    output req_first__RDY,
    output req_first,
    input  req_deq__ENA,
    input  out_heard__ENA,
    input  out_heard_meth,
    input  out_heard_v,
    output out_heard__RDY
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first set request strictly after
// index `last`, wrapping from N-1 to 0. Purely combinational.
module rr_pick #(
  parameter int N  = 10,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  // cand[k] is the index examined at scan position k (k=0 is last+1)
  logic [IW-1:0] cand [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [IW:0] sum;
    assign sum       = {1'b0, last} + (IW+1)'(gi + 1);
    assign cand[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
  end

  // Scan from the far end so the nearest requester overwrites the others
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/ivector_heard_arbiter.sv
// Round-robin scheduler sharing the single heard port among NREQ method FIFOs,
// with a one-entry registered output stage that drains and reloads in one cycle.
module ivector_heard_arbiter
  import ivector_pkg::*;
#(
  parameter int NREQ       = IVECTOR_NREQ,
  parameter int DATA_WIDTH = IVECTOR_DATA_WIDTH,
  parameter int METH_WIDTH = IVECTOR_METH_WIDTH
) (
  input  logic                   CLK,
  input  logic                   nRST,
  ivector_heard_arbiter_if.master bus,
  output logic [31:0]            grant_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic                  valid_reg;
  logic [IW-1:0]         meth_reg;
  logic [DATA_WIDTH-1:0] v_reg;
  logic [IW-1:0]         last_reg;
  logic [31:0]           grant_count_reg;

  logic                  drain;
  logic                  load_ok;
  logic                  found;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] payload [NREQ];

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req   (bus.req_first__RDY),
    .last  (last_reg),
    .found (found),
    .idx   (idx)
  );

  // nRST gates every strobe so nothing is dequeued or delivered during reset
  assign drain   = nRST & valid_reg & bus.out_heard__RDY;
  assign load_ok = ~valid_reg | drain;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign payload[gi]          = bus.req_first[gi*DATA_WIDTH +: DATA_WIDTH];
    assign bus.req_deq__ENA[gi] = nRST & load_ok & found & (idx == IW'(gi));
  end

  assign bus.out_heard__ENA = drain;
  assign bus.out_heard_meth = nRST ? METH_WIDTH'(meth_reg) : '0;
  assign bus.out_heard_v    = nRST ? v_reg : '0;
  assign grant_count        = grant_count_reg;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid_reg       <= 1'b0;
      meth_reg        <= '0;
      v_reg           <= '0;
      last_reg        <= IW'(NREQ - 1);
      grant_count_reg <= '0;
    end else begin
      if (drain) begin
        grant_count_reg <= grant_count_reg + 32'd1;
      end
      if (load_ok) begin
        if (found) begin
          valid_reg <= 1'b1;
          meth_reg  <= idx;
          v_reg     <= payload[idx];
          last_reg  <= idx;
        end else begin
          valid_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ivector_heard_arbiter.sv
// Directed and randomized check of ivector_heard_arbiter against a
// distance-based round-robin reference model.
module tb_ivector_heard_arbiter;
  import ivector_pkg::*;

  localparam int N  = IVECTOR_NREQ;
  localparam int DW = IVECTOR_DATA_WIDTH;
  localparam int MW = IVECTOR_METH_WIDTH;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] grant_count;

  always #5 CLK = ~CLK;

  ivector_heard_arbiter_if #(.NREQ(N), .DATA_WIDTH(DW), .METH_WIDTH(MW)) bus ();

  ivector_heard_arbiter #(.NREQ(N), .DATA_WIDTH(DW), .METH_WIDTH(MW)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .bus         (bus),
    .grant_count (grant_count)
  );

  int checks   = 0;
  int failures = 0;

  // stimulus
  logic [N-1:0]  ready;
  logic [DW-1:0] data [N];
  logic          rdy;

  // reference model: one held response, last served index, delivery count
  bit            m_valid;
  int            m_meth;
  logic [DW-1:0] m_v;
  int            m_last;
  int unsigned   m_count;
  bit            m_known;

  // winner = ready index with the smallest forward distance past `last`
  function automatic int pick(logic [N-1:0] r, int last);
    int best, bd, d;
    best = -1;
    bd   = N;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        d = (i - last - 1 + 2 * N) % N;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.req_first__RDY = ready;
    for (int i = 0; i < N; i++) bus.req_first[i*DW +: DW] = data[i];
    bus.out_heard__RDY = rdy;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) data[i] = DW'($urandom);
  endtask

  // one clock: check outputs mid-cycle, then advance the model on the edge
  task automatic cycle();
    int           w;
    bit           exp_ena, exp_load;
    logic [N-1:0] exp_deq;
    apply();
    @(negedge CLK);
    w        = pick(ready, m_last);
    exp_ena  = nRST && m_valid && rdy;
    exp_load = nRST && (!m_valid || rdy) && (w >= 0);
    exp_deq  = '0;
    if (exp_load) exp_deq[w] = 1'b1;
    chk("heard_ena", 64'(bus.out_heard__ENA), 64'(exp_ena));
    chk("deq_ena", 64'(bus.req_deq__ENA), 64'(exp_deq));
    chk("heard_meth", 64'(bus.out_heard_meth), nRST ? 64'(m_meth) : 64'd0);
    chk("heard_v", 64'(bus.out_heard_v), nRST ? 64'(m_v) : 64'd0);
    if (m_known) chk("grant_count", 64'(grant_count), 64'(m_count));
    if (exp_ena)
      $display("deliver meth=%0d v=%08h count=%0d", m_meth, m_v, m_count + 1);
    @(posedge CLK);
    if (!nRST) begin
      m_valid = 1'b0;
      m_meth  = 0;
      m_v     = '0;
      m_last  = N - 1;
      m_count = 0;
      m_known = 1'b1;
    end else begin
      if (exp_ena) m_count++;
      if (!m_valid || rdy) begin
        if (w >= 0) begin
          m_valid = 1'b1;
          m_meth  = w;
          m_v     = data[w];
          m_last  = w;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
    #1;
  endtask

  initial begin
    m_valid = 1'b0;
    m_meth  = 0;
    m_v     = '0;
    m_last  = N - 1;
    m_count = 0;
    m_known = 1'b0;
    ready   = '0;
    rdy     = 1'b1;
    for (int i = 0; i < N; i++) data[i] = '0;

    // reset, then idle
    nRST = 1'b0;
    repeat (2) cycle();
    nRST = 1'b1;
    repeat (20) cycle();

    // single request from FIFO 3
    ready    = '0;
    ready[3] = 1'b1;
    data[3]  = 32'hDEADBEEF;
    cycle();
    ready = '0;
    repeat (2) cycle();
    chk("single_count", 64'(grant_count), 64'd1);

    // all FIFOs ready after a fresh reset: 0..9,0,1
    nRST = 1'b0;
    cycle();
    nRST  = 1'b1;
    ready = '1;
    repeat (13) begin
      randomize_data();
      cycle();
    end
    chk("all_ready_count", 64'(grant_count), 64'd12);
    ready = '0;
    repeat (2) cycle();

    // backpressure with 0 and 5 ready
    nRST = 1'b0;
    cycle();
    nRST     = 1'b1;
    ready    = '0;
    ready[0] = 1'b1;
    ready[5] = 1'b1;
    randomize_data();
    rdy = 1'b1;
    cycle();
    rdy = 1'b0;
    repeat (4) cycle();
    rdy = 1'b1;
    repeat (3) cycle();
    ready = '0;
    repeat (2) cycle();

    // wrap: last=9 after reset, 9 and 2 ready -> 2 first
    nRST = 1'b0;
    cycle();
    nRST     = 1'b1;
    ready    = '0;
    ready[9] = 1'b1;
    ready[2] = 1'b1;
    randomize_data();
    repeat (4) cycle();

    // reset in the middle of a stream
    ready = '1;
    repeat (4) begin
      randomize_data();
      cycle();
    end
    nRST = 1'b0;
    cycle();
    nRST = 1'b1;
    repeat (3) cycle();

    // randomized traffic with backpressure and occasional resets
    repeat (400) begin
      ready = N'($urandom);
      if ($urandom_range(0, 1) == 1) ready &= N'($urandom);
      rdy  = ($urandom_range(0, 3) != 0);
      nRST = ($urandom_range(0, 60) != 0);
      randomize_data();
      cycle();
    end
    nRST = 1'b1;
    ready = '0;
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ivector_heard_arbiter.md
# ivector_heard_arbiter

Round-robin response scheduler that shares the single `out$heard` indication port between NREQ per-method response FIFOs, replacing fixed-priority selection where method 0 can starve method 9. It sits between the per-method ping-pong FIFO bank and the `heard` consumer. It dequeues at most one FIFO per cycle and holds the selected `{meth, v}` in a one-entry output register. The consumer sees registered outputs at full throughput of one response per cycle.

## Interface
Parameters:
- NREQ, 10, number of requesting FIFOs; index = method number
- DATA_WIDTH, 32, payload width of `v`
- METH_WIDTH, 32, width of `meth`

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, synchronous, active-low
- req$first__RDY  in  NREQ  bit i = FIFO i has data (its `first__RDY & deq__RDY`)
- req$first  in  NREQ*DATA_WIDTH  FIFO i head payload in bits [i*DATA_WIDTH +: DATA_WIDTH]
- req$deq__ENA  out  NREQ  one-hot (or zero) dequeue strobe to FIFO i
- out$heard__ENA  out  1  response delivered this cycle
- out$heard$meth  out  METH_WIDTH  method index of held response, zero-extended
- out$heard$v  out  DATA_WIDTH  held payload
- out$heard__RDY  in  1  consumer can accept
- grant_count  out  32  total responses delivered since reset, wraps

## Operation
- State: `valid` (1b), `meth_r`, `v_r`, `last` (index of last grant), `grant_count`.
- `out$heard__ENA = valid & out$heard__RDY`. The ENA is never asserted without RDY.
- `drain = out$heard__ENA`. `load_ok = !valid | drain`.
- Pick: scan indices `last+1, last+2, …` mod NREQ. Winner = first i with `req$first__RDY[i]`. Wrap is to 0 after NREQ-1.
- When `load_ok` and a winner exists:
  - `req$deq__ENA[winner]=1`
  - `meth_r<=winner`, `v_r<=req$first[winner]`, `valid<=1`, `last<=winner`
- When `load_ok` and no winner:
  - `req$deq__ENA=0`
  - `valid<=0` if drained, else stays 0
- When `valid & !out$heard__RDY`: hold all state, no dequeue.
- `grant_count` increments on every `drain` (not on load).
- `out$heard$meth/v` drive `meth_r/v_r` directly, with no combinational path from `req$*`.
- `req$deq__ENA` is combinational from `req$first__RDY`, `valid`, `out$heard__RDY`, and `last`.

## Timing
- Reset values: `valid=0`, `meth_r=0`, `v_r=0`, `last=NREQ-1` (index 0 wins first), `grant_count=0`.
- Output values during reset: `out$heard__ENA=0`, `out$heard$meth=0`, `out$heard$v=0`, `req$deq__ENA=0`.
- Latency: FIFO dequeued in cycle N → `out$heard__ENA` earliest in cycle N+1.
- Throughput: 1 response/cycle under continuous RDY, via simultaneous drain and load.
- Backpressure: `out$heard__RDY=0` freezes the register. No FIFO is dequeued, so no data is lost.
- Fairness: with all NREQ requesting and RDY held high, each index is served exactly once per NREQ consecutive deliveries.
- A single requester is served every cycle it has data.
- Reset asserted mid-operation: the held response is discarded. The FIFO entry was already dequeued and is lost; this is accepted by the system protocol. `last` returns to NREQ-1.
- `req$deq__ENA` is never asserted during reset cycles.

## Structure
- Shared package `ivector_pkg`:
  - `IVECTOR_NREQ=10`, `IVECTOR_DATA_WIDTH=32`, `IVECTOR_METH_WIDTH=32`
  - typedef `ivector_heard_t {meth, v}`, also reused by the FIFO bank
- One sub-module `rr_pick #(N)`: inputs `req[N]`, `last`; outputs `found`, `idx`. Purely combinational rotating priority encoder, instantiated once.
- Top level holds the output register, `last`, the counter, and the dequeue decode.

## Test plan
- Reset then idle: all `req$first__RDY=0` → `out$heard__ENA=0`, `req$deq__ENA=0`, `grant_count=0` for 20 cycles.
- Single request: FIFO 3 ready with `v=0xDEADBEEF` for one cycle, RDY=1 → `deq__ENA[3]` in cycle N; `heard__ENA`, `meth=3`, `v=0xDEADBEEF` in N+1; `grant_count=1`.
- All 10 ready continuously, RDY=1 → meth sequence 0,1,…,9,0,1 on consecutive cycles; `grant_count=12` after 12 deliveries.
- Backpressure: 0 and 5 ready, RDY low for 4 cycles after first load → `meth=0` held, no `deq__ENA` for those 4 cycles; on RDY high, deliver 0 then 5 back-to-back.
- Wrap: `last=9`, only 9 and 2 ready → 2 served before 9.
- Reset mid-stream: assert nRST=0 while `valid=1` → next cycle `valid=0`, `grant_count=0`; after release, index 0 has priority.
